pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch program-counter generator for the in-order cache CPU front end. It issues a stream of instruction addresses to the fetch stage over a valid/ready handshake. It also accepts pipeline redirects (branch/jump resolution) and trap redirects. Each redirect bumps a fetch epoch, so downstream stages can drop wrong-path instructions. Misaligned redirect targets enter a fault state that only a trap redirect can leave.

## Interface
- XLEN, 64, address width in bits.
- RESET_VECTOR, 64'h8000_0000, first PC issued after reset; truncated to XLEN.
- INST_BYTES, 4, PC increment per accepted fetch; power of two, 2 or 4.
- EPOCH_W, 2, width of the epoch tag.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_ready  in  1  fetch stage accepts pc_o this cycle.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  XLEN  redirect target.
- trap_valid  in  1  trap/exception redirect request; overrides redirect_valid.
- trap_pc  in  XLEN  trap handler address.
- stall  in  1  freezes PC advance; pc_valid forced low while asserted.
- pc_o  out  XLEN  current fetch address.
- pc_valid  out  1  pc_o is a valid fetch request.
- pc_epoch  out  EPOCH_W  epoch tag travelling with pc_o.
- misaligned  out  1  sticky fault flag; high in FAULT state.

## Operation
- States: BOOT, RUN, FAULT.
- Reset (rst=1 at edge): state=BOOT, pc_o=0, pc_valid=0, pc_epoch=0, misaligned=0. All inputs are ignored while rst=1.
- BOOT: at the first edge with rst=0, pc_o<=RESET_VECTOR, pc_valid<=1 (if stall=0), state<=RUN. redirect_valid and trap_valid are ignored in BOOT.
- RUN, per-edge priority, highest first:
  1. trap_valid: pc_o<=trap_pc, epoch+1.
  2. redirect_valid: pc_o<=redirect_pc, epoch+1.
  3. pc_valid & fetch_ready: pc_o<=pc_o+INST_BYTES.
  4. Otherwise hold.
- Alignment check applies only to the redirect target (case 2). redirect_pc[log2(INST_BYTES)-1:0] != 0 means state<=FAULT, misaligned<=1, pc_valid<=0, pc_o<=redirect_pc, epoch+1.
- FAULT: pc_valid=0 and redirect_valid is ignored. trap_valid sets pc_o<=trap_pc, epoch+1, misaligned<=0, state<=RUN. Trap targets are not alignment-checked.
- stall:
  - pc_valid is registered and equals (state==RUN) & !stall for the next cycle.
  - PC increment is suppressed while stall is asserted.
  - Redirects and traps are still accepted during stall.
- Arithmetic:
  - PC increment wraps modulo 2^XLEN: all-ones minus INST_BYTES-1 → 0.
  - Epoch wraps modulo 2^EPOCH_W: 3 → 0 for EPOCH_W=2.

## Timing
- Single-cycle state machine; every output is registered. There is no combinational input-to-output path.
- Handshake:
  - Transfer occurs at an edge where pc_valid=1 and fetch_ready=1.
  - While pc_valid=1 and fetch_ready=0, pc_o and pc_epoch stay stable unless a redirect or trap occurs; a redirect/trap may replace an unaccepted request.
- Back-to-back throughput: one PC per cycle when fetch_ready stays high.
- Redirect latency: target appears on pc_o one edge after redirect_valid is sampled, with the new epoch the same cycle.
- Redirect and accepted fetch in the same cycle: redirect wins. The accepted PC counts as transferred with the old epoch; there is no increment.
- trap_valid and redirect_valid together: trap_pc is used, and epoch increments once.
- rst asserted mid-operation: all state returns to reset values at that edge, regardless of other inputs. The next rst=0 edge re-enters BOOT behaviour.

## Test plan
- Reset release, fetch_ready=1 constant → pc_valid=0 for the first cycle; then pc_o=0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles; epoch=0.
- fetch_ready=0 for 3 cycles at pc_o=0x8000_0008 → pc_o held at 0x8000_0008 with pc_valid=1; after fetch_ready=1, next pc_o=0x8000_000C.
- redirect_valid with redirect_pc=0x8000_1000 while fetch_ready=1 → next pc_o=0x8000_1000, epoch 0→1. Four more redirects wrap epoch 1→2→3→0→1.
- trap_valid (trap_pc=0x8000_0100) and redirect_valid (0x8000_2000) together → pc_o=0x8000_0100, epoch incremented by exactly 1.
- redirect_pc=0x8000_0002 → misaligned=1, pc_valid=0, redirects ignored. trap_pc=0x8000_0200 → misaligned=0, pc_valid=1, pc_o=0x8000_0200.
- XLEN=32, pc_o=0xFFFF_FFFC, fetch accepted → pc_o=0x0000_0000. Then rst pulse with stall=1 → pc_o=0, and pc_valid stays 0 until stall drops.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with redirect epochs and misalignment fault
module pc_gen #(
  parameter int          XLEN         = 64,
  parameter logic [63:0] RESET_VECTOR = 64'h8000_0000,
  parameter int          INST_BYTES   = 4,
  parameter int          EPOCH_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_ready,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic               stall,
  output logic [XLEN-1:0]    pc_o,
  output logic               pc_valid,
  output logic [EPOCH_W-1:0] pc_epoch,
  output logic               misaligned
);
  localparam int AW = $clog2(INST_BYTES);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t               r_state, w_state;
  logic [XLEN-1:0]      r_pc, w_pc;
  logic [EPOCH_W-1:0]   r_epoch, w_epoch;
  logic                 r_valid, w_valid, r_mis;
  logic                 w_rd_mis;
  assign w_rd_mis   = redirect_pc[AW-1:0] != '0;
  assign pc_o       = r_pc;
  assign pc_valid   = r_valid;
  assign pc_epoch   = r_epoch;
  assign misaligned = r_mis;
  // Next state: boot vector, then trap > redirect > accepted fetch > hold; FAULT only leaves on trap
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_epoch = r_epoch;
    if (r_state == BOOT) begin
      w_state = RUN;
      w_pc    = RESET_VECTOR[XLEN-1:0];
    end else if (trap_valid) begin
      w_state = RUN;
      w_pc    = trap_pc;
      w_epoch = r_epoch + EPOCH_W'(1);
    end else if (r_state == RUN && redirect_valid) begin
      w_state = w_rd_mis ? FAULT : RUN;
      w_pc    = redirect_pc;
      w_epoch = r_epoch + EPOCH_W'(1);
    end else if (r_state == RUN && r_valid && fetch_ready && !stall) begin
      w_pc    = r_pc + XLEN'(INST_BYTES);
    end
    w_valid = (w_state == RUN) && !stall;
  end
  // State register; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= '0;
      r_epoch <= '0;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_epoch <= w_epoch;
      r_valid <= w_valid;
      r_mis   <= w_state == FAULT;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: vector table, 32-bit wrap sequence and randomized model check for pc_gen
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst, fetch_ready, redirect_valid, trap_valid, stall;
  logic [63:0] redirect_pc, trap_pc;
  logic [63:0] pc64;
  logic [31:0] pc32;
  logic        v64, v32, m64, m32;
  logic [1:0]  e64, e32;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .stall(stall),
    .pc_o(pc64), .pc_valid(v64), .pc_epoch(e64), .misaligned(m64)
  );

  pc_gen #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[31:0]),
    .trap_valid(trap_valid), .trap_pc(trap_pc[31:0]), .stall(stall),
    .pc_o(pc32), .pc_valid(v32), .pc_epoch(e32), .misaligned(m32)
  );

  typedef struct {
    logic        d32;
    logic        rst, stall, rdy, rv, tv;
    logic [63:0] rpc, tpc;
    logic [63:0] pc;
    logic        v;
    logic [1:0]  e;
    logic        m;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic d32, logic r, logic s, logic rdy, logic rv, logic [63:0] rpc,
                              logic tv, logic [63:0] tpc, logic [63:0] pc, logic v, logic [1:0] e, logic m);
    vec_t x;
    x.d32 = d32; x.rst = r; x.stall = s; x.rdy = rdy; x.rv = rv; x.rpc = rpc;
    x.tv = tv; x.tpc = tpc; x.pc = pc; x.v = v; x.e = e; x.m = m;
    return x;
  endfunction

  task automatic chk(string nm, int idx, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic step(logic r, logic s, logic rdy, logic rv, logic [63:0] rpc, logic tv, logic [63:0] tpc);
    rst = r; stall = s; fetch_ready = rdy;
    redirect_valid = rv; redirect_pc = rpc; trap_valid = tv; trap_pc = tpc;
    @(posedge clk);
    #1;
  endtask

  // reference model: boot/fault flags plus plain integer arithmetic
  logic [63:0] m_pc;
  int          m_epoch;
  bit          m_valid, m_boot, m_fault;

  task automatic model(logic r, logic s, logic rdy, logic rv, logic [63:0] rpc, logic tv, logic [63:0] tpc);
    if (r) begin
      m_boot = 1; m_fault = 0; m_pc = 0; m_valid = 0; m_epoch = 0;
    end else if (m_boot) begin
      m_boot = 0; m_pc = 64'h8000_0000; m_valid = !s;
    end else if (m_fault) begin
      if (tv) begin
        m_pc = tpc; m_epoch = (m_epoch + 1) % 4; m_fault = 0;
      end
      m_valid = !m_fault && !s;
    end else begin
      if (tv) begin
        m_pc = tpc; m_epoch = (m_epoch + 1) % 4;
      end else if (rv) begin
        m_pc = rpc; m_epoch = (m_epoch + 1) % 4;
        if (rpc % 4 != 0) m_fault = 1;
      end else if (m_valid && rdy && !s) begin
        m_pc = m_pc + 4;
      end
      m_valid = !m_fault && !s;
    end
  endtask

  initial begin
    // d32 r  s  rdy rv rpc                tv tpc                pc                 v  e  m
    vt.push_back(mk(0, 1, 0, 1, 0, 64'h0,            0, 64'h0,            64'h0,            0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 64'h0,            0, 64'h0,            64'h8000_0000,    1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 64'h0,            0, 64'h0,            64'h8000_0004,    1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 64'h0,            0, 64'h0,            64'h8000_0008,    1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 64'h0,            0, 64'h0,            64'h8000_0008,    1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 64'h0,            0, 64'h0,            64'h8000_0008,    1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 64'h0,            0, 64'h0,            64'h8000_0008,    1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 64'h0,            0, 64'h0,            64'h8000_000C,    1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 64'h8000_1000,    0, 64'h0,            64'h8000_1000,    1, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 64'h8000_1010,    0, 64'h0,            64'h8000_1010,    1, 2, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 64'h8000_1020,    0, 64'h0,            64'h8000_1020,    1, 3, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 64'h8000_1030,    0, 64'h0,            64'h8000_1030,    1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 64'h8000_1040,    0, 64'h0,            64'h8000_1040,    1, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 64'h8000_2000,    1, 64'h8000_0100,    64'h8000_0100,    1, 2, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 64'h8000_0002,    0, 64'h0,            64'h8000_0002,    0, 3, 1));
    vt.push_back(mk(0, 0, 0, 1, 1, 64'h8000_3000,    0, 64'h0,            64'h8000_0002,    0, 3, 1));
    vt.push_back(mk(0, 0, 0, 1, 0, 64'h0,            1, 64'h8000_0200,    64'h8000_0200,    1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 64'h0,            0, 64'h0,            64'h8000_0200,    0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 1, 64'h8000_4000,    0, 64'h0,            64'h8000_4000,    0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 64'h0,            0, 64'h0,            64'h8000_4000,    1, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 64'h0,            0, 64'h0,            64'h8000_4004,    1, 1, 0));
    vt.push_back(mk(0, 1, 1, 1, 1, 64'h8000_5000,    1, 64'h8000_6000,    64'h0,            0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 64'h8000_5000,    1, 64'h1234_0000,    64'h8000_0000,    1, 0, 0));
    // 32-bit instance: wrap at top of address space, then reset under stall
    vt.push_back(mk(1, 1, 0, 0, 0, 64'h0,            0, 64'h0,            64'h0,            0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 64'h0,            0, 64'h0,            64'h8000_0000,    1, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 1, 64'hFFFF_FFFC,    0, 64'h0,            64'hFFFF_FFFC,    1, 1, 0));
    vt.push_back(mk(1, 0, 0, 1, 0, 64'h0,            0, 64'h0,            64'h0,            1, 1, 0));
    vt.push_back(mk(1, 1, 1, 1, 0, 64'h0,            0, 64'h0,            64'h0,            0, 0, 0));
    vt.push_back(mk(1, 0, 1, 1, 0, 64'h0,            0, 64'h0,            64'h8000_0000,    0, 0, 0));
    vt.push_back(mk(1, 0, 1, 1, 0, 64'h0,            0, 64'h0,            64'h8000_0000,    0, 0, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 64'h0,            0, 64'h0,            64'h8000_0000,    1, 0, 0));
    vt.push_back(mk(1, 0, 0, 1, 0, 64'h0,            0, 64'h0,            64'h8000_0004,    1, 0, 0));

    rst = 1; stall = 0; fetch_ready = 0; redirect_valid = 0; trap_valid = 0;
    redirect_pc = 0; trap_pc = 0;
    @(posedge clk);
    #1;
    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].stall, vt[i].rdy, vt[i].rv, vt[i].rpc, vt[i].tv, vt[i].tpc);
      if (vt[i].d32) begin
        chk("vec32_pc", i, {32'h0, pc32}, vt[i].pc);
        chk("vec32_valid", i, 64'(v32), 64'(vt[i].v));
        chk("vec32_epoch", i, 64'(e32), 64'(vt[i].e));
        chk("vec32_mis", i, 64'(m32), 64'(vt[i].m));
      end else begin
        chk("vec_pc", i, pc64, vt[i].pc);
        chk("vec_valid", i, 64'(v64), 64'(vt[i].v));
        chk("vec_epoch", i, 64'(e64), 64'(vt[i].e));
        chk("vec_mis", i, 64'(m64), 64'(vt[i].m));
      end
    end

    for (int c = 0; c < 3000; c++) begin
      logic        r, s, rdy, rv, tv;
      logic [63:0] rpc, tpc;
      r   = (c == 0) || ($urandom_range(99) == 0);
      s   = $urandom_range(7) == 0;
      rdy = $urandom_range(3) != 0;
      rv  = $urandom_range(5) == 0;
      tv  = $urandom_range(11) == 0;
      rpc = {$urandom, $urandom};
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(15) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      tpc = {$urandom, $urandom};
      step(r, s, rdy, rv, rpc, tv, tpc);
      model(r, s, rdy, rv, rpc, tv, tpc);
      chk("rnd_pc", c, pc64, m_pc);
      chk("rnd_valid", c, 64'(v64), 64'(m_valid));
      chk("rnd_epoch", c, 64'(e64), 64'(m_epoch));
      chk("rnd_mis", c, 64'(m64), 64'(m_fault));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
